// File: rtl/window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : window_buffer
// Purpose  : Sliding FILTER_SIZE x FILTER_SIZE window generator over a raster
//            pixel stream.  The window is held in FILTER_SIZE-1 row buffers
//            plus a shift-register window.  Strided windows are selected with
//            phase counters, so no modulo logic is needed.
// Options  : define WINDOW_BUFFER_FRAME_END_EN to add the frame_end output,
//            which flags the last window of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module window_buffer #(
  parameter int D_WIDTH     = 8,
  parameter int IMAGE_SIZE  = 256,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clk_en,
  input  logic [D_WIDTH-1:0]                       input_data,
  input  logic                                     input_valid,
  output logic [FILTER_SIZE*FILTER_SIZE*D_WIDTH-1:0] output_data,
  output logic                                     valid
`ifdef WINDOW_BUFFER_FRAME_END_EN
  ,
  output logic                                     frame_end
`endif
);

  localparam int C_CNT_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int C_PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int C_WIN_W = FILTER_SIZE * FILTER_SIZE * D_WIDTH;

  localparam logic [C_CNT_W-1:0] C_POS_MAX   = C_CNT_W'(IMAGE_SIZE - 1);
  localparam logic [C_CNT_W-1:0] C_POS_FIRST = C_CNT_W'(FILTER_SIZE - 1);
  localparam logic [C_PH_W-1:0]  C_PH_MAX    = C_PH_W'(STRIDE - 1);

  // Pixel acceptance: no backpressure, every qualified pixel is consumed.
  logic accept;
  assign accept = clk_en & input_valid;

  // Position of the pixel currently being offered, and stride phases that
  // are zero exactly when (pos - FILTER_SIZE + 1) is a multiple of STRIDE.
  logic [C_CNT_W-1:0] col_q, col_d;
  logic [C_CNT_W-1:0] row_q, row_d;
  logic [C_PH_W-1:0]  col_ph_q, col_ph_d;
  logic [C_PH_W-1:0]  row_ph_q, row_ph_d;

  logic [C_WIN_W-1:0] win_q, win_d;
  logic               valid_q, valid_d;
  logic               win_ok;

  // Row buffers: line_buf[0] holds the previous row, line_buf[k] is k+1
  // rows above the incoming pixel.  Not reset; window gating hides stale data.
  logic [D_WIDTH-1:0] line_buf [FILTER_SIZE-1][IMAGE_SIZE];
  // Column entering the window: col_vec[0] is the new pixel (bottom row),
  // col_vec[FILTER_SIZE-1] is the oldest row (top of window).
  logic [D_WIDTH-1:0] col_vec [FILTER_SIZE];

  // Assemble the incoming window column from the pixel and the row buffers.
  always_comb begin
    for (int k = 0; k < FILTER_SIZE; k++) begin
      col_vec[k] = '0;
    end
    col_vec[0] = input_data;
    for (int k = 1; k < FILTER_SIZE; k++) begin
      col_vec[k] = line_buf[k-1][col_q];
    end
  end

  // Advance column/row position and stride phases on each accepted pixel.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (accept) begin
      if (col_q == C_POS_MAX) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_q == C_POS_MAX) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (row_q >= C_POS_FIRST) begin
            row_ph_d = (row_ph_q == C_PH_MAX) ? '0 : row_ph_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q >= C_POS_FIRST) begin
          col_ph_d = (col_ph_q == C_PH_MAX) ? '0 : col_ph_q + 1'b1;
        end
      end
    end
  end

  // A window is complete when the current pixel is a stride-aligned
  // bottom-right corner; columns before FILTER_SIZE-1 would span a row wrap.
  always_comb begin
    win_ok  = (row_q >= C_POS_FIRST) && (col_q >= C_POS_FIRST) &&
              (row_ph_q == '0) && (col_ph_q == '0);
    valid_d = clk_en ? (accept && win_ok) : valid_q;
  end

  // Shift the window left by one column and load the new column on the right.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          if (c < FILTER_SIZE - 1) begin
            win_d[(r*FILTER_SIZE+c)*D_WIDTH +: D_WIDTH] =
              win_q[(r*FILTER_SIZE+c+1)*D_WIDTH +: D_WIDTH];
          end else begin
            win_d[(r*FILTER_SIZE+c)*D_WIDTH +: D_WIDTH] =
              col_vec[FILTER_SIZE-1-r];
          end
        end
      end
    end
  end

  // Row buffer update: each buffer passes its old pixel one row further up.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < FILTER_SIZE - 1; k++) begin
        line_buf[k][col_q] <= col_vec[k];
      end
    end
  end

  // Control and window registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
      win_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      win_q    <= win_d;
      valid_q  <= valid_d;
    end
  end

  assign output_data = win_q;
  assign valid       = valid_q;

`ifdef WINDOW_BUFFER_FRAME_END_EN
  // Position of the last stride-aligned window corner in a row/column.
  localparam int C_LAST_INT = (FILTER_SIZE - 1) +
                              ((IMAGE_SIZE - FILTER_SIZE) / STRIDE) * STRIDE;
  localparam logic [C_CNT_W-1:0] C_POS_LAST = C_CNT_W'(C_LAST_INT);

  logic frame_end_q, frame_end_d;

  // Flag the final window of the frame alongside its valid pulse.
  always_comb begin
    frame_end_d = clk_en ? (accept && win_ok &&
                            (row_q == C_POS_LAST) && (col_q == C_POS_LAST))
                         : frame_end_q;
  end

  // Frame-end register, cleared with the rest of the control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= frame_end_d;
    end
  end

  assign frame_end = frame_end_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_buffer
// Purpose  : Directed self-checking bench for window_buffer on a 4x4 image
//            with a 2x2 window, run side by side at STRIDE=1 and STRIDE=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [7:0]  input_data = '0;
  logic        input_valid = 1'b0;
  logic [31:0] data_s1, data_s2;
  logic        valid_s1, valid_s2;
`ifdef WINDOW_BUFFER_FRAME_END_EN
  logic        fe_s1, fe_s2;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses_s1 = 0;
  int pulses_s2 = 0;

  // Hand-computed top-left pixel index of the window completed by frame
  // pixel i (-1: no window), for STRIDE=1 and STRIDE=2.
  int exp_s1 [16] = '{-1, -1, -1, -1, -1, 0, 1, 2, -1, 4, 5, 6, -1, 8, 9, 10};
  int exp_s2 [16] = '{-1, -1, -1, -1, -1, 0, -1, 2, -1, -1, -1, -1, -1, 8, -1, 10};

  always #5 clk = ~clk;

  window_buffer #(.D_WIDTH(8), .IMAGE_SIZE(4), .FILTER_SIZE(2), .STRIDE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .input_data(input_data),
    .input_valid(input_valid), .output_data(data_s1), .valid(valid_s1)
`ifdef WINDOW_BUFFER_FRAME_END_EN
    , .frame_end(fe_s1)
`endif
  );

  window_buffer #(.D_WIDTH(8), .IMAGE_SIZE(4), .FILTER_SIZE(2), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .input_data(input_data),
    .input_valid(input_valid), .output_data(data_s2), .valid(valid_s2)
`ifdef WINDOW_BUFFER_FRAME_END_EN
    , .frame_end(fe_s2)
`endif
  );

  // Window whose top-left pixel value is b: {(1,1),(1,0),(0,1),(0,0)}.
  function automatic logic [31:0] win(input int b);
    return {8'(b + 5), 8'(b + 4), 8'(b + 1), 8'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, then check both instances just after the edge.
  task automatic step(input bit iv, input logic [7:0] d, input bit ce,
                      input int e1, input int e2, input bit fe);
    input_valid = iv;
    input_data  = d;
    clk_en      = ce;
    @(posedge clk);
    #1;
    chk("s1_valid", 64'(valid_s1), 64'(e1 >= 0));
    if (e1 >= 0) chk("s1_data", 64'(data_s1), 64'(win(e1)));
    chk("s2_valid", 64'(valid_s2), 64'(e2 >= 0));
    if (e2 >= 0) chk("s2_data", 64'(data_s2), 64'(win(e2)));
`ifdef WINDOW_BUFFER_FRAME_END_EN
    chk("s1_frame_end", 64'(fe_s1), 64'(fe));
    chk("s2_frame_end", 64'(fe_s2), 64'(fe));
`endif
    if (ce && valid_s1) pulses_s1++;
    if (ce && valid_s2) pulses_s2++;
  endtask

  task automatic do_reset(input bit ce);
    rst_n       = 1'b0;
    clk_en      = ce;
    input_valid = 1'b1;
    input_data  = 8'hA5;
    @(posedge clk);
    #1;
    chk("rst_s1_valid", 64'(valid_s1), 64'd0);
    chk("rst_s1_data",  64'(data_s1),  64'd0);
    chk("rst_s2_valid", 64'(valid_s2), 64'd0);
    chk("rst_s2_data",  64'(data_s2),  64'd0);
`ifdef WINDOW_BUFFER_FRAME_END_EN
    chk("rst_s1_frame_end", 64'(fe_s1), 64'd0);
`endif
    rst_n = 1'b1;
  endtask

  // Feed n pixels of a frame with values off+i; optional idle gaps and a
  // three-cycle stall right after pixel 5 (garbage offered while stalled).
  task automatic frame(input int off, input int n, input bit gaps, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) step(1'b0, 8'h55, 1'b1, -1, -1, 1'b0);
      step(1'b1, 8'(off + i), 1'b1,
           (exp_s1[i] >= 0) ? exp_s1[i] + off : -1,
           (exp_s2[i] >= 0) ? exp_s2[i] + off : -1,
           (i == 15));
      if (stall && i == 5) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b1, 8'hEE, 1'b0, off, off, 1'b0);
        end
      end
    end
  endtask

  initial begin
    // Reset with the stall active must still clear the outputs.
    do_reset(1'b0);
    step(1'b0, 8'h00, 1'b1, -1, -1, 1'b0);

    // Two back-to-back frames: 0..15 then 16..31.
    frame(0, 16, 1'b0, 1'b0);
    frame(16, 16, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, -1, -1, 1'b0);

    // Same frame shape with idle gaps and a stall holding the first window.
    frame(32, 16, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, -1, -1, 1'b0);

    // Partial frame up to pixel 9, reset, then a full fresh frame.
    frame(64, 10, 1'b0, 1'b0);
    do_reset(1'b1);
    frame(100, 16, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, -1, -1, 1'b0);

    // Window counts: 9+9+9+4+9 at STRIDE=1, 4+4+4+2+4 at STRIDE=2.
    chk("s1_pulse_count", 64'(pulses_s1), 64'd40);
    chk("s2_pulse_count", 64'(pulses_s2), 64'd18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter IMAGE_SIZE, default 256, pixels per row and rows per frame (square image).
REQ-003 SHALL have parameter FILTER_SIZE, default 2, window edge length (range 2..IMAGE_SIZE).
REQ-004 SHALL have parameter STRIDE, default 1, window step in both directions (range 1..FILTER_SIZE).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port clk_en, input, 1, global stall; when low, no state changes.
REQ-008 SHALL have port input_data, input, D_WIDTH, pixel in raster order (row-major, top-left first).
REQ-009 SHALL have port input_valid, input, 1, input_data is a new pixel this cycle.
REQ-010 SHALL have port output_data, output, FILTER_SIZE*FILTER_SIZE*D_WIDTH, window; element (r,c) at bits [(r*FILTER_SIZE+c)*D_WIDTH +: D_WIDTH], with r=0 the top (oldest) row and c=0 the left column.
REQ-011 SHALL have port valid, output, 1, output_data holds a complete window this cycle; feeds the downstream convolutional/pooling layer input.

Function
REQ-012 SHALL hold FILTER_SIZE-1 row buffers of IMAGE_SIZE pixels plus a FILTER_SIZE x FILTER_SIZE shift-register window.
REQ-013 SHALL accept a pixel only when clk_en=1 and input_valid=1; no backpressure exists and every accepted pixel is consumed.
REQ-014 SHALL track the accepted pixel's position with col and row counters (0..IMAGE_SIZE-1); col wraps to 0 after IMAGE_SIZE-1 and row increments; after pixel (IMAGE_SIZE-1, IMAGE_SIZE-1), both wrap to 0 with no idle cycle required, and the next pixel starts a new frame.
REQ-015 SHALL treat the accepted pixel at (row,col) as the window's bottom-right element.
REQ-016 SHALL assert valid for exactly one cycle, one cycle after acceptance, iff row>=FILTER_SIZE-1, col>=FILTER_SIZE-1, (row-FILTER_SIZE+1) mod STRIDE=0, and (col-FILTER_SIZE+1) mod STRIDE=0.
REQ-017 SHALL have a latency of exactly 1 clk_en-qualified cycle from the accepted last pixel to valid; output_data SHALL be registered.
REQ-018 SHALL never emit a window that spans two rows (column wrap) or two frames.
REQ-019 SHALL hold valid and output_data stable while clk_en=0; a valid pulse pending when clk_en drops SHALL persist until the first cycle with clk_en=1, then clear unless a new window is produced.
REQ-020 SHALL drive valid=0 in any clk_en=1 cycle that follows a cycle with input_valid=0.
REQ-021 SHALL produce ((IMAGE_SIZE-FILTER_SIZE)/STRIDE+1)^2 windows per frame (integer division).

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge and regardless of clk_en, clear row, col, valid, and output_data to 0.
REQ-023 SHALL not reset row buffer contents; stale data SHALL never appear in a valid window because REQ-016 gating restarts from row 0.
REQ-024 SHALL, on reset mid-frame, discard the partial frame and treat the first pixel after reset as (0,0).

Configuration
REQ-025 SHALL compile in, when WINDOW_BUFFER_FRAME_END_EN is defined, a 1-bit output frame_end (reset 0) that asserts together with valid for the last window of each frame and is 0 otherwise.
REQ-026 SHALL, when WINDOW_BUFFER_FRAME_END_EN is undefined, omit the frame_end port and logic; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover IMAGE_SIZE=4, FILTER_SIZE=2, STRIDE=1, pixels 0..15 continuous -> 9 valid pulses; the first, the cycle after pixel 5, with elements (0,0)=0, (0,1)=1, (1,0)=4, (1,1)=5; the last is {10,11,14,15}.
REQ-028 SHALL cover the same stimulus with STRIDE=2 -> exactly 4 windows in order {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
REQ-029 SHALL cover stimulus from REQ-027 with input_valid=0 gaps and a clk_en=0 burst of 3 cycles after pixel 5 -> identical window sequence; valid for {0,1,4,5} held through the stall.
REQ-030 SHALL cover rst_n=0 for 1 cycle after pixel 9, then pixels 0..15 -> no valid before the new pixel 5; 9 correct windows after that.
REQ-031 SHALL cover two back-to-back frames (pixels 0..15, then 16..31) -> 18 windows; frame 2's first is {16,17,20,21}; with WINDOW_BUFFER_FRAME_END_EN, frame_end is high only on {10,11,14,15} and {26,27,30,31}.
